// File: rtl/thinpad_mem_pkg.sv
// Shared types and constants for the SRAM/UART memory arbiter.
// UART states exist only when UART_MMIO_EN is defined.
package thinpad_mem_pkg;

  localparam int unsigned RAM_ADDR_W_DEF     = 18;
  localparam logic [15:0] NOP_INSTR          = 16'h0800;
  localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR1      = 3'd2,
    ST_WR2      = 3'd3
`ifdef UART_MMIO_EN
    ,
    ST_UART_RD1 = 3'd4,
    ST_UART_RD2 = 3'd5,
    ST_UART_WR1 = 3'd6,
    ST_UART_WR2 = 3'd7
`endif
  } state_e;

  typedef enum logic [1:0] {
    CLS_SRAM,
    CLS_UART_DATA,
    CLS_UART_STAT
  } addr_class_e;

  // Request granted in IDLE this cycle, after priority and address decode.
  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_IF_RD,
    REQ_MEM_RD,
    REQ_MEM_WR,
    REQ_UART_RD,
    REQ_UART_WR,
    REQ_STAT_RD,
    REQ_STAT_WR
  } req_e;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request/response bundle of the memory arbiter.
// master = IF/MEM pipeline stages, slave = arbiter.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    input  if_rdata, if_done, if_stall, mem_rdata, mem_done
  );

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    output if_rdata, if_done, if_stall, mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_arbiter_addr_decode.sv
// Classifies a MEM-stage word address as SRAM, UART data or UART status.
// Without UART_MMIO_EN every address is SRAM.
module mem_addr_decode
  import thinpad_mem_pkg::*;
#(
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
  input  logic [15:0] addr_i,
  output addr_class_e class_o
);

`ifdef UART_MMIO_EN
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    class_o = CLS_SRAM;
    if (addr_i == UART_DATA_ADDR) begin
      class_o = CLS_UART_DATA;
    end else if (addr_i == UART_STAT_ADDR) begin
      class_o = CLS_UART_STAT;
    end
  end
`else
  logic unused_decode;
  assign unused_decode = ^{addr_i, UART_DATA_ADDR, UART_STAT_ADDR};
  assign class_o       = CLS_SRAM;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter for IF and MEM stages, MEM first; all bus pins registered.
// UART_MMIO_EN adds the memory-mapped UART data/status registers.
module mem_arbiter
  import thinpad_mem_pkg::*;
#(
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
  parameter int unsigned RAM_ADDR_W     = RAM_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_arbiter_if.slave          bus,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [15:0]           ram_dout,
  output logic                  ram_doe,
  input  logic [15:0]           ram_din,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic                  uart_rdn,
  output logic                  uart_wrn,
  input  logic                  uart_tbre,
  input  logic                  uart_tsre,
  input  logic                  uart_data_ready
);

  state_e                  state_q, state_d;
  owner_e                  owner_q, owner_d;
  req_e                    req;
  addr_class_e             mem_cls;
  logic                    can_accept;
  logic [RAM_ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [15:0]             ram_dout_q, ram_dout_d;
  logic                    ram_doe_q, ram_doe_d;
  logic                    ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                    if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic [15:0]             if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
`ifdef UART_MMIO_EN
  logic                    uart_rdn_q, uart_rdn_d, uart_wrn_q, uart_wrn_d;
`else
  logic                    unused_uart_status;
  assign unused_uart_status = ^{uart_tbre, uart_tsre, uart_data_ready};
`endif

  function automatic logic [RAM_ADDR_W-1:0] word_addr(input logic [15:0] a);
    return {{(RAM_ADDR_W-16){1'b0}}, a};
  endfunction

  mem_addr_decode #(
    .UART_DATA_ADDR (UART_DATA_ADDR),
    .UART_STAT_ADDR (UART_STAT_ADDR)
  ) u_decode (
    .addr_i  (bus.mem_addr),
    .class_o (mem_cls)
  );

  // The done-low condition gives requesters one idle cycle to drop or advance.
  assign can_accept = (state_q == ST_IDLE) && !if_done_q && !mem_done_q;

  always_comb begin
    req = REQ_NONE;
    if (can_accept) begin
      if (bus.mem_wr) begin
        case (mem_cls)
          CLS_UART_DATA: req = REQ_UART_WR;
          CLS_UART_STAT: req = REQ_STAT_WR;
          default:       req = REQ_MEM_WR;
        endcase
      end else if (bus.mem_rd) begin
        case (mem_cls)
          CLS_UART_DATA: req = REQ_UART_RD;
          CLS_UART_STAT: req = REQ_STAT_RD;
          default:       req = REQ_MEM_RD;
        endcase
      end else if (bus.if_req) begin
        req = REQ_IF_RD;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        case (req)
          REQ_IF_RD, REQ_MEM_RD: state_d = ST_RD;
          REQ_MEM_WR:            state_d = ST_WR1;
`ifdef UART_MMIO_EN
          REQ_UART_RD:           state_d = ST_UART_RD1;
          REQ_UART_WR:           state_d = ST_UART_WR1;
`endif
          default:               state_d = ST_IDLE;
        endcase
      end
      ST_WR1:      state_d = ST_WR2;
`ifdef UART_MMIO_EN
      ST_UART_RD1: state_d = ST_UART_RD2;
      ST_UART_WR1: state_d = ST_UART_WR2;
`endif
      default:     state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered pins; strobes idle high unless a state pulls them.
  always_comb begin
    owner_d     = owner_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    ram_doe_d   = 1'b0;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
`ifdef UART_MMIO_EN
    uart_rdn_d  = 1'b1;
    uart_wrn_d  = 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
        case (req)
          REQ_IF_RD: begin
            owner_d    = OWN_IF;
            ram_addr_d = word_addr(bus.if_addr);
            ce_n_d     = 1'b0;
            oe_n_d     = 1'b0;
          end
          REQ_MEM_RD: begin
            owner_d    = OWN_MEM;
            ram_addr_d = word_addr(bus.mem_addr);
            ce_n_d     = 1'b0;
            oe_n_d     = 1'b0;
          end
          REQ_MEM_WR: begin
            ram_addr_d = word_addr(bus.mem_addr);
            ram_dout_d = bus.mem_wdata;
            ram_doe_d  = 1'b1;
            ce_n_d     = 1'b0;
          end
`ifdef UART_MMIO_EN
          REQ_UART_RD: uart_rdn_d = 1'b0;
          REQ_UART_WR: begin
            ram_dout_d = bus.mem_wdata;
            ram_doe_d  = 1'b1;
          end
          REQ_STAT_RD: begin
            mem_rdata_d = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
            mem_done_d  = 1'b1;
          end
`endif
          REQ_STAT_WR: mem_done_d = 1'b1;
          default: ;
        endcase
      end
      ST_RD: begin
        if (owner_q == OWN_IF) begin
          if_rdata_d = ram_din;
          if_done_d  = 1'b1;
        end else begin
          mem_rdata_d = ram_din;
          mem_done_d  = 1'b1;
        end
      end
      ST_WR1: begin
        ram_doe_d = 1'b1;
        ce_n_d    = 1'b0;
        we_n_d    = 1'b0;
      end
      ST_WR2: begin
        ram_doe_d  = 1'b1;
        mem_done_d = 1'b1;
      end
`ifdef UART_MMIO_EN
      ST_UART_RD1: uart_rdn_d = 1'b0;
      ST_UART_RD2: begin
        mem_rdata_d = ram_din;
        mem_done_d  = 1'b1;
      end
      ST_UART_WR1: begin
        ram_doe_d  = 1'b1;
        uart_wrn_d = 1'b0;
      end
      ST_UART_WR2: begin
        ram_doe_d  = 1'b1;
        mem_done_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_IF;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_doe_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= NOP_INSTR;
      mem_rdata_q <= '0;
`ifdef UART_MMIO_EN
      uart_rdn_q  <= 1'b1;
      uart_wrn_q  <= 1'b1;
`endif
    end else begin
      owner_q     <= owner_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_doe_q   <= ram_doe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef UART_MMIO_EN
      uart_rdn_q  <= uart_rdn_d;
      uart_wrn_q  <= uart_wrn_d;
`endif
    end
  end

  assign ram_addr      = ram_addr_q;
  assign ram_dout      = ram_dout_q;
  assign ram_doe       = ram_doe_q;
  assign ram_ce_n      = ce_n_q;
  assign ram_oe_n      = oe_n_q;
  assign ram_we_n      = we_n_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_stall  = bus.if_req & ~if_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_done  = mem_done_q;
`ifdef UART_MMIO_EN
  assign uart_rdn      = uart_rdn_q;
  assign uart_wrn      = uart_wrn_q;
`else
  assign uart_rdn      = 1'b1;
  assign uart_wrn      = 1'b1;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: SRAM/UART device models on the pins and
// a word-level reference memory for expected read data.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] ram_addr;
  logic [15:0] ram_dout;
  logic [15:0] ram_din = 16'h0000;
  logic        ram_doe, ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;
  logic        uart_tbre = 1'b0, uart_tsre = 1'b0, uart_data_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .ram_addr        (ram_addr),
    .ram_dout        (ram_dout),
    .ram_doe         (ram_doe),
    .ram_din         (ram_din),
    .ram_ce_n        (ram_ce_n),
    .ram_oe_n        (ram_oe_n),
    .ram_we_n        (ram_we_n),
    .uart_rdn        (uart_rdn),
    .uart_wrn        (uart_wrn),
    .uart_tbre       (uart_tbre),
    .uart_tsre       (uart_tsre),
    .uart_data_ready (uart_data_ready)
  );

  int checks = 0;
  int errors = 0;

  // Device side: SRAM contents as written over the pins, plus UART byte registers.
  logic [15:0] sram    [logic [17:0]];
  // Reference side: what the bench itself believes each word holds.
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] uart_rx      = 16'h0000;
  logic [15:0] uart_tx_last = 16'h0000;
  logic [17:0] last_rd_addr = '0;
  int we_low = 0, ce_low = 0, wrn_low = 0, rdn_low = 0;
  int both_low = 0, wrn_total = 0, rdn_total = 0;

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (!ram_ce_n && !ram_we_n) begin
        we_low++;
        if (ram_doe) sram[ram_addr] = ram_dout;
      end
      if (!ram_ce_n) ce_low++;
      if (!uart_wrn) begin
        wrn_low++;
        wrn_total++;
        uart_tx_last = ram_dout;
      end
      if (!uart_rdn) begin
        rdn_low++;
        rdn_total++;
      end
      if (!ram_we_n && !ram_oe_n) both_low++;
      if (!ram_ce_n && !ram_oe_n) last_rd_addr = ram_addr;
    end
    if (!ram_ce_n && !ram_oe_n)
      ram_din = sram.exists(ram_addr) ? sram[ram_addr] : dflt(ram_addr[15:0]);
    else if (!uart_rdn)
      ram_din = uart_rx;
    else
      ram_din = 16'($urandom);
  end

  task automatic mem_op(input string tag, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input int exp_lat, input int exp_ce,
                        input int exp_we, input int exp_wrn, input int exp_rdn,
                        output logic [15:0] rdata);
    int lat;
    bit seen;
    we_low = 0; ce_low = 0; wrn_low = 0; rdn_low = 0;
    bus.mem_wr = wr; bus.mem_rd = !wr; bus.mem_addr = addr; bus.mem_wdata = wdata;
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      lat = i;
      if (i == 1) begin
        bus.mem_addr  = 16'($urandom);
        bus.mem_wdata = 16'($urandom);
      end
      if (bus.mem_done) seen = 1'b1;
    end
    bus.mem_wr = 1'b0; bus.mem_rd = 1'b0;
    rdata = bus.mem_rdata;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_ce_cycles"}, ce_low, exp_ce);
    check({tag, "_we_cycles"}, we_low, exp_we);
    check({tag, "_wrn_cycles"}, wrn_low, exp_wrn);
    check({tag, "_rdn_cycles"}, rdn_low, exp_rdn);
    tick();
    check({tag, "_done_width"}, bus.mem_done, 1'b0);
  endtask

  task automatic if_fetch(input string tag, input logic [15:0] addr, input logic [15:0] exp_data);
    int lat;
    int stall_bad;
    bit seen;
    bus.if_req = 1'b1; bus.if_addr = addr;
    lat = 0; stall_bad = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      lat = i;
      if (i == 1) bus.if_addr = 16'($urandom);
      if (bus.if_done) seen = 1'b1;
      else if (!bus.if_stall) stall_bad++;
    end
    bus.if_req = 1'b0;
    check({tag, "_latency"}, lat, 2);
    check({tag, "_stall"}, stall_bad, 0);
    check({tag, "_rdata"}, bus.if_rdata, exp_data);
    check({tag, "_addr"}, last_rd_addr, {2'b00, addr});
    tick();
    check({tag, "_done_width"}, bus.if_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r, d, a, p;
    int md_e, ia_e, id_e, sbad;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;

    // Reset state
    tick(); tick();
    check("rst_if_rdata", bus.if_rdata, 16'h0800);
    check("rst_mem_rdata", bus.mem_rdata, 16'h0000);
    check("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}, 5'b11111);
    check("rst_doe_done", {ram_doe, bus.if_done, bus.mem_done}, 3'b000);
    check("rst_addr_dout", {ram_addr, ram_dout}, 34'h0);
    rst = 1'b1;
    tick();

    // IF-only read
    sram[18'h00003] = 16'h6901; ref_mem[16'h0003] = 16'h6901;
    if_fetch("if_only", 16'h0003, 16'h6901);

    // Simultaneous IF and MEM write: write first, fetch two cycles after mem_done
    p = 16'($urandom);
    sram[18'h00010] = p; ref_mem[16'h0010] = p; ref_mem[16'h0008] = 16'h0007;
    we_low = 0;
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    bus.mem_wr = 1'b1; bus.mem_addr = 16'h0008; bus.mem_wdata = 16'h0007;
    md_e = 0; ia_e = 0; id_e = 0; sbad = 0;
    for (int e = 1; e <= 30 && id_e == 0; e++) begin
      tick();
      if (bus.mem_done && md_e == 0) begin
        md_e = e;
        bus.mem_wr = 1'b0;
      end
      if (!ram_ce_n && !ram_oe_n && ia_e == 0) ia_e = e;
      if (bus.if_done) id_e = e;
      else if (!bus.if_stall) sbad++;
    end
    bus.if_req = 1'b0;
    check("sim_mem_done_edge", md_e, 3);
    check("sim_if_accept_edge", ia_e, 5);
    check("sim_if_done_edge", id_e, 6);
    check("sim_we_cycles", we_low, 1);
    check("sim_stall", sbad, 0);
    check("sim_if_rdata", bus.if_rdata, p);
    check("sim_if_addr", last_rd_addr, 18'h00010);
    check("sim_sram_word", sram.exists(18'h00008) ? sram[18'h00008] : 16'hxxxx, 16'h0007);
    tick();

    // Store then load
    d = 16'($urandom); ref_mem[16'h00CF] = d;
    mem_op("sw_cf", 1'b1, 16'h00CF, d, 3, 2, 1, 0, 0, r);
    mem_op("lw_cf", 1'b0, 16'h00CF, 16'h0000, 2, 1, 0, 0, 0, r);
    check("lw_cf_rdata", r, d);

    // Randomized loads/stores/fetches over a small address pool
    for (int n = 0; n < 16; n++) begin
      a = 16'h0100 + 16'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: begin
          d = 16'($urandom); ref_mem[a] = d;
          mem_op("rnd_sw", 1'b1, a, d, 3, 2, 1, 0, 0, r);
        end
        1: begin
          p = exp_word(a);
          mem_op("rnd_lw", 1'b0, a, 16'h0000, 2, 1, 0, 0, 0, r);
          check("rnd_lw_rdata", r, p);
        end
        default: if_fetch("rnd_if", a, exp_word(a));
      endcase
    end

`ifdef UART_MMIO_EN
    mem_op("uart_wr", 1'b1, 16'hBF00, 16'h0041, 3, 0, 0, 1, 0, r);
    check("uart_tx_data", uart_tx_last, 16'h0041);
    uart_tbre = 1'b1; uart_tsre = 1'b1; uart_data_ready = 1'b0;
    mem_op("stat_rd1", 1'b0, 16'hBF01, 16'h0000, 1, 0, 0, 0, 0, r);
    check("stat_rd1_rdata", r, 16'h0001);
    uart_tbre = 1'b1; uart_tsre = 1'b0; uart_data_ready = 1'b1;
    mem_op("stat_rd2", 1'b0, 16'hBF01, 16'h0000, 1, 0, 0, 0, 0, r);
    check("stat_rd2_rdata", r, 16'h0002);
    uart_rx = 16'h0055;
    mem_op("uart_rd", 1'b0, 16'hBF00, 16'h0000, 3, 0, 0, 0, 2, r);
    check("uart_rd_rdata", r, 16'h0055);
    mem_op("stat_wr", 1'b1, 16'hBF01, 16'h1234, 1, 0, 0, 0, 0, r);
`else
    mem_op("mmio_off_rd", 1'b0, 16'hBF00, 16'h0000, 2, 1, 0, 0, 0, r);
    check("mmio_off_rdata", r, dflt(16'hBF00));
    check("mmio_off_addr", last_rd_addr, 18'h0BF00);
    d = 16'($urandom); ref_mem[16'hBF00] = d;
    mem_op("mmio_off_wr", 1'b1, 16'hBF00, d, 3, 2, 1, 0, 0, r);
    mem_op("mmio_off_rd2", 1'b0, 16'hBF00, 16'h0000, 2, 1, 0, 0, 0, r);
    check("mmio_off_rd2_rdata", r, exp_word(16'hBF00));
    check("mmio_off_uart_strobes", wrn_total + rdn_total, 0);
`endif

    // Reset in the middle of a write, while we_n is low
    bus.mem_wr = 1'b1; bus.mem_addr = 16'h0200; bus.mem_wdata = 16'hBEEF;
    for (int i = 0; i < 10 && ram_we_n !== 1'b0; i++) tick();
    check("mid_wr_reached_wr2", ram_we_n, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_we_n", ram_we_n, 1'b1);
    check("mid_rst_doe", ram_doe, 1'b0);
    check("mid_rst_ce_n", ram_ce_n, 1'b1);
    check("mid_rst_if_rdata", bus.if_rdata, 16'h0800);
    check("mid_rst_mem_rdata", bus.mem_rdata, 16'h0000);
    check("mid_rst_addr", ram_addr, 18'h0);
    check("mid_rst_done", bus.mem_done, 1'b0);
    bus.mem_wr = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    if_fetch("post_rst_if", 16'h0003, 16'h6901);

    check("oe_we_never_both_low", both_low, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
